// File: rtl/jtframe_rom_arbiter.sv
// Round-robin read arbiter sharing one SDRAM bank among CH ROM clients.
// Each client owns a one-entry cache (tag/valid/data) and sees a
// cs/addr/data/ok handshake; misses are served one at a time through the
// bank's rd/ack/dok/rdy protocol.
module jtframe_rom_arbiter #(
  parameter int                CH     = 4,
  parameter int                AW     = 22,
  parameter int                DW     = 32,
  parameter logic [CH*AW-1:0]  OFFSET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [CH-1:0]    ch_cs,
  input  logic [CH*AW-1:0] ch_addr,
  output logic [CH*DW-1:0] ch_data,
  output logic [CH-1:0]    ch_ok,
  output logic [AW-1:0]    ba_addr,
  output logic             ba_rd,
  input  logic             ba_ack,
  input  logic             ba_dok,
  input  logic             ba_rdy,
  input  logic [15:0]      data_read
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;
  localparam int NW = DW / 16;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t        state, state_nxt;
  logic [CH-1:0] valid;
  logic [CH-1:0] miss;
  logic [AW-1:0] tag  [CH];
  logic [DW-1:0] data [CH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] pick;
  logic [AW-1:0] gaddr;
  logic [AW-1:0] pick_addr;
  logic [AW-1:0] pick_bank;
  logic          found;
  logic          wc;
  logic          flushed;
  int unsigned   idx;

  // Per-channel hit/miss detection and cached data fan-out
  always_comb begin
    miss    = '0;
    ch_ok   = '0;
    ch_data = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      miss[i]             = ch_cs[i] & (~valid[i] | (tag[i] != ch_addr[i*AW +: AW]));
      ch_ok[i]            = ch_cs[i] & valid[i] & (tag[i] == ch_addr[i*AW +: AW]);
      ch_data[i*DW +: DW] = data[i];
    end
  end

  // First missing channel scanning upward from the round-robin pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < CH; k++) begin
      idx = (32'(ptr) + k) % CH;
      if (!found && miss[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    pick_addr = ch_addr[pick*AW +: AW];
    pick_bank = pick_addr + OFFSET[pick*AW +: AW];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: flush held high keeps the arbiter from granting
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found && !flush) state_nxt = REQ;
      REQ:     if (ba_ack)          state_nxt = DATA;
      DATA:    if (ba_rdy)          state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Bank read request is asserted for the whole REQ state
  always_comb begin
    ba_rd = (state == REQ);
  end

  // Grant latch, word capture, cache fill and flush handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      ptr     <= '0;
      gnt     <= '0;
      gaddr   <= '0;
      ba_addr <= '0;
      wc      <= 1'b0;
      flushed <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found && !flush) begin
            gnt     <= pick;
            gaddr   <= pick_addr;
            ba_addr <= pick_bank;
            wc      <= 1'b0;
            flushed <= 1'b0;
          end
        end
        DATA: begin
          if (ba_dok) begin
            for (int unsigned w = 0; w < NW; w++) begin
              if (w == 32'(wc)) data[gnt][w*16 +: 16] <= data_read;
            end
            wc <= 1'b1;
          end
          if (ba_rdy) begin
            tag[gnt] <= gaddr;
            if (!flushed && !flush) valid[gnt] <= 1'b1;
            ptr <= (gnt == PW'(CH-1)) ? '0 : gnt + 1'b1;
          end
        end
        default: ;
      endcase
      // A flush wins over a fill landing in the same cycle; an in-flight
      // transfer remembers it so its fill never becomes valid.
      if (flush) begin
        valid <= '0;
        if (state != IDLE) flushed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arbiter.sv
// Bench for jtframe_rom_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level cache/arbiter model.
module tb_jtframe_rom_arbiter;

  localparam int CH = 4;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam logic [CH*AW-1:0] OFF = {22'h3FFFF8, 22'h000200, 22'h010000, 22'h000000};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CH-1:0]    ch_cs = '0;
  logic [CH*AW-1:0] ch_addr = '0;
  logic [CH*DW-1:0] ch_data;
  logic [CH-1:0]    ch_ok;
  logic [AW-1:0]    ba_addr;
  logic             ba_rd;
  logic             ba_ack = 1'b0;
  logic             ba_dok = 1'b0;
  logic             ba_rdy = 1'b0;
  logic [15:0]      data_read = '0;

  logic [1:0]       b_cs = '0;
  logic [2*AW-1:0]  b_addr = '0;
  logic [31:0]      b_data;
  logic [1:0]       b_ok;
  logic [AW-1:0]    b_ba_addr;
  logic             b_ba_rd;
  logic             b_flush = 1'b0;
  logic             b_ack = 1'b0;
  logic             b_dok = 1'b0;
  logic             b_rdy = 1'b0;
  logic [15:0]      b_dr = '0;

  always #5 clk = ~clk;

  jtframe_rom_arbiter #(.CH(CH), .AW(AW), .DW(DW), .OFFSET(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ch_cs(ch_cs), .ch_addr(ch_addr),
    .ch_data(ch_data), .ch_ok(ch_ok), .ba_addr(ba_addr), .ba_rd(ba_rd),
    .ba_ack(ba_ack), .ba_dok(ba_dok), .ba_rdy(ba_rdy), .data_read(data_read)
  );

  jtframe_rom_arbiter #(.CH(2), .AW(AW), .DW(16), .OFFSET({22'd0, 22'd2})) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .ch_cs(b_cs), .ch_addr(b_addr),
    .ch_data(b_data), .ch_ok(b_ok), .ba_addr(b_ba_addr), .ba_rd(b_ba_rd),
    .ba_ack(b_ack), .ba_dok(b_dok), .ba_rdy(b_rdy), .data_read(b_dr)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model: per-channel cache plus transfer phase (0 idle, 1 req, 2 data)
  int unsigned   off_tab [CH] = '{32'h0, 32'h10000, 32'h200, 32'h3FFFF8};
  bit            m_valid [CH];
  logic [AW-1:0] m_tag   [CH];
  logic [DW-1:0] m_data  [CH];
  int            m_ptr, m_g, m_phase, m_wc;
  logic [AW-1:0] m_gaddr;
  bit            m_fl;
  int            dut_g [$];
  logic [AW-1:0] last_ba;
  int            exp_rr [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] get_addr(input int i);
    return ch_addr[i*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    ch_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] bank_of(input int i, input logic [AW-1:0] a);
    return AW'((32'(a) + off_tab[i]) % 32'h400000);
  endfunction

  function automatic bit m_miss(input int i);
    return ch_cs[i] && (!m_valid[i] || m_tag[i] != get_addr(i));
  endfunction

  function automatic bit any_miss();
    if (flush) return 1'b0;
    for (int i = 0; i < CH; i++) if (m_miss(i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_ptr = 0; m_g = 0; m_phase = 0; m_wc = 0; m_gaddr = '0; m_fl = 1'b0;
  endtask

  // advance the model across the coming clock edge using the current inputs
  task automatic model_edge();
    int pre;
    int i;
    pre = m_phase;
    if (m_phase == 0) begin
      if (!flush) begin
        for (int k = 0; k < CH; k++) begin
          i = (m_ptr + k) % CH;
          if (m_phase == 0 && m_miss(i)) begin
            m_g = i; m_gaddr = get_addr(i); m_phase = 1; m_fl = 1'b0;
          end
        end
      end
    end else if (m_phase == 1) begin
      if (ba_ack) begin m_phase = 2; m_wc = 0; end
    end else begin
      if (ba_dok && m_wc < DW/16) begin
        m_data[m_g][16*m_wc +: 16] = data_read;
        m_wc++;
      end
      if (ba_rdy) begin
        m_tag[m_g]   = m_gaddr;
        m_valid[m_g] = !(m_fl || flush);
        m_ptr        = (m_g + 1) % CH;
        m_phase      = 0;
      end
    end
    if (flush) begin
      for (int k = 0; k < CH; k++) m_valid[k] = 1'b0;
      if (pre != 0) m_fl = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("ba_rd", 64'(ba_rd), 64'(m_phase == 1));
    if (m_phase == 1) chk("ba_addr", 64'(ba_addr), 64'(bank_of(m_g, m_gaddr)));
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("ch_ok%0d", i), 64'(ch_ok[i]),
          64'(ch_cs[i] && m_valid[i] && m_tag[i] == get_addr(i)));
      chk($sformatf("ch_data%0d", i), 64'(ch_data[i*DW +: DW]), 64'(m_data[i]));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // wait (bounded) for a bank request, log the granted channel, then accept it
  task automatic serve_req(input int lat);
    int n;
    int g;
    n = 0;
    while (ba_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 64'(ba_rd), 64'd1);
    g = -1;
    for (int i = CH-1; i >= 0; i--) if (bank_of(i, get_addr(i)) == ba_addr) g = i;
    dut_g.push_back(g);
    last_ba = ba_addr;
    repeat (lat) tick();
    ba_ack = 1'b1;
    tick();
    ba_ack = 1'b0;
  endtask

  task automatic serve_data(input logic [15:0] w0, input logic [15:0] w1, input int gap, input bit early);
    data_read = w0; ba_dok = 1'b1; ba_rdy = early;
    tick();
    ba_dok = 1'b0; ba_rdy = 1'b0;
    if (!early) begin
      repeat (gap) tick();
      data_read = w1; ba_dok = 1'b1; ba_rdy = 1'b1;
      tick();
    end
    ba_dok = 1'b0; ba_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1);
  end

  initial begin
    model_reset();
    ch_cs = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ba_rd", 64'(ba_rd), 64'd0);
    chk("rst_ba_addr", 64'(ba_addr), 64'd0);
    chk("rst_ch_ok", 64'(ch_ok), 64'd0);
    chk("rst_ch_data_lo", 64'(ch_data[63:0]), 64'd0);
    chk("rst_ch_data_hi", 64'(ch_data[127:64]), 64'd0);
    ch_cs = '0;
    rst_n = 1'b1;
    tick();

    // single miss on channel 1 with a bank offset
    ch_cs = 4'b0010;
    set_addr(1, 22'h20);
    tick();
    chk("t1_ba_addr", 64'(ba_addr), 64'h10020);
    serve_req(1);
    serve_data(16'h1234, 16'hABCD, 0, 1'b0);
    chk("t1_ok", 64'(ch_ok[1]), 64'd1);
    chk("t1_data", 64'(ch_data[63:32]), 64'hABCD1234);
    repeat (4) tick();
    chk("t1_no_second_rd", 64'(ba_rd), 64'd0);

    // asynchronous reset while a request is pending
    ch_cs = 4'b0011;
    set_addr(0, 22'h55);
    tick();
    chk("rq_rd_high", 64'(ba_rd), 64'd1);
    chk("rq_hit1", 64'(ch_ok[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rq_rst_rd", 64'(ba_rd), 64'd0);
    chk("rq_rst_ok", 64'(ch_ok), 64'd0);
    chk("rq_rst_addr", 64'(ba_addr), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    ch_cs = '0;
    rst_n = 1'b1;
    tick();

    // round robin: all four miss, channel 0 misses again after its fill
    dut_g.delete();
    for (int i = 0; i < CH; i++) set_addr(i, 22'(32'h40 * (i + 1)));
    ch_cs = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve_req(k % 2);
      serve_data(16'($urandom), 16'($urandom), k % 3, 1'b0);
      if (k == 0) set_addr(0, 22'h44);
    end
    chk("rr_count", 64'(dut_g.size()), 64'd5);
    for (int k = 0; k < 5 && k < dut_g.size(); k++)
      chk($sformatf("rr_order%0d", k), 64'(dut_g[k]), 64'(exp_rr[k]));

    // address change during the data phase
    ch_cs = 4'b0100;
    set_addr(2, 22'h100);
    serve_req(0);
    set_addr(2, 22'h104);
    serve_data(16'h1111, 16'h2222, 1, 1'b0);
    chk("amf_ok_low", 64'(ch_ok[2]), 64'd0);
    serve_req(0);
    chk("amf_rereq_addr", 64'(last_ba), 64'h304);
    serve_data(16'h3333, 16'h4444, 0, 1'b0);
    chk("amf_ok", 64'(ch_ok[2]), 64'd1);

    // flush pulse in DATA, then flush held high
    set_addr(3, 22'h200);
    ch_cs = 4'b1001;
    serve_req(0);
    chk("fl_pre_ok0", 64'(ch_ok[0]), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    serve_data(16'h5555, 16'h6666, 0, 1'b0);
    chk("fl_all_ok_low", 64'(ch_ok), 64'd0);
    ch_cs = 4'b1000;
    serve_req(0);
    chk("fl_rereq_ch", 64'(dut_g[$]), 64'd3);
    flush = 1'b1;
    serve_data(16'h7070, 16'h0707, 0, 1'b0);
    repeat (8) tick();
    chk("fl_hold_no_rd", 64'(ba_rd), 64'd0);
    flush = 1'b0;
    serve_req(0);
    chk("fl_after_ch", 64'(dut_g[$]), 64'd3);
    serve_data(16'h8888, 16'h9999, 0, 1'b0);
    chk("fl_after_ok", 64'(ch_ok[3]), 64'd1);

    // early ba_rdy in two-word mode keeps the old upper half
    set_addr(3, 22'h300);
    serve_req(0);
    serve_data(16'h7777, 16'h0000, 0, 1'b1);
    chk("early_lo", 64'(ch_data[111:96]), 64'h7777);
    chk("early_hi", 64'(ch_data[127:112]), 64'h9999);
    chk("early_ok", 64'(ch_ok[3]), 64'd1);

    // stray data strobes while idle
    ch_cs = '0;
    ba_dok = 1'b1;
    data_read = 16'hDEAD;
    repeat (3) tick();
    ba_dok = 1'b0;

    // random traffic
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 2) == 0) set_addr(i, 22'(32'h1000 * i + 4 * $urandom_range(0, 3)));
      ch_cs = 4'($urandom_range(1, 15));
      if (any_miss()) begin
        serve_req(int'($urandom_range(0, 3)));
        case ($urandom_range(0, 5))
          0: set_addr(m_g, get_addr(m_g) + 22'd4);
          1: begin flush = 1'b1; tick(); flush = 1'b0; end
          2: ch_cs[m_g] = 1'b0;
          default: ;
        endcase
        serve_data(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0);
      end else begin
        repeat (2) tick();
      end
    end

    // single-word instance: offset addition wraps at 2^AW
    ch_cs = '0;
    tick();
    b_cs = 2'b01;
    b_addr[AW-1:0] = 22'h3FFFFF;
    tick();
    chk("w_rd", 64'(b_ba_rd), 64'd1);
    chk("w_addr", 64'(b_ba_addr), 64'h000001);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("w_rd_low", 64'(b_ba_rd), 64'd0);
    b_dok = 1'b1; b_rdy = 1'b1; b_dr = 16'h5A5A;
    tick();
    b_dok = 1'b0; b_rdy = 1'b0;
    chk("w_ok", 64'(b_ok[0]), 64'd1);
    chk("w_data", 64'(b_data[15:0]), 64'h5A5A);
    repeat (3) tick();
    chk("w_no_second_rd", 64'(b_ba_rd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
